// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// blank pattern, hex-to-segment map and digit-index width.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        s = SEG_BLANK;
        case (nibble)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver with PWM brightness and double-buffered
// loading. Define SEG_SCAN_LZS_EN to enable leading-zero suppression.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIV_BITS    = 16,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*DIGITS-1:0]           number,
    input  logic [DIGITS-1:0]             blank,
    input  logic [DIGITS-1:0]             dp,
    input  logic                          load,
    input  logic [BRIGHT_BITS-1:0]        brightness,
    output logic                          busy,
    output logic [6:0]                    seg,
    output logic                          dp_n,
    output logic [DIGITS-1:0]             an,
    output logic [idx_width(DIGITS)-1:0]  digit_idx
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]    div_cnt;
    logic [DIGITS-1:0][3:0] pend_number, disp_number;
    logic [DIGITS-1:0]      pend_blank, disp_blank;
    logic [DIGITS-1:0]      pend_dp, disp_dp;

    logic slot_tick, commit;
    assign slot_tick = &div_cnt;
    assign commit    = slot_tick && (digit_idx == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; commit therefore moves the *old* pending contents even
    // when a load lands in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            busy        <= 1'b0;
            // NOTE: the buffers are a handful of flops, not a RAM, so they are
            // reset to a blanked frame and the display comes up dark.
            pend_number <= '0;
            pend_blank  <= '1;
            pend_dp     <= '0;
            disp_number <= '0;
            disp_blank  <= '1;
            disp_dp     <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (slot_tick)
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            // Outside a pending load both buffers are equal, so copying
            // unconditionally at the frame boundary is harmless.
            if (commit) begin
                disp_number <= pend_number;
                disp_blank  <= pend_blank;
                disp_dp     <= pend_dp;
            end
            if (load) begin
                pend_number <= number;
                pend_blank  <= blank;
                pend_dp     <= dp;
                busy        <= 1'b1;
            end else if (commit) begin
                busy <= 1'b0;
            end
        end
    end

    logic [BRIGHT_BITS-1:0] pwm_top;
    logic                   pwm_on;
    logic [3:0]             cur_nibble;
    logic [6:0]             cur_seg;
    logic                   digit_dark;

    assign pwm_top    = div_cnt[DIV_BITS-1 -: BRIGHT_BITS];
    assign pwm_on     = (pwm_top <= brightness);
    assign cur_nibble = disp_number[digit_idx];

    seg_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

`ifdef SEG_SCAN_LZS_EN
    logic [DIGITS-1:0] lz_dark;

    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin : lzs
        logic zeros_above;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned and no latch is inferred.
        zeros_above = 1'b1;
        lz_dark     = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zeros_above = zeros_above && (disp_number[i] == 4'h0);
            lz_dark[i]  = zeros_above;
        end
    end

    assign digit_dark = disp_blank[digit_idx] | lz_dark[digit_idx];
`else
    assign digit_dark = disp_blank[digit_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst || !pwm_on || digit_dark) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(DIGITS'(1) << digit_idx);
            seg  <= cur_seg;
            dp_n <= ~disp_dp[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2)
// against a cycle-count based reference model; honours SEG_SCAN_LZS_EN.
module tb_seg_scan_display;

    localparam int DIGITS      = 4;
    localparam int DIV_BITS    = 4;
    localparam int BRIGHT_BITS = 2;
    localparam int SLOT        = 1 << DIV_BITS;
    localparam int FRAME       = SLOT * DIGITS;
    localparam int PWM_STEP    = 1 << (DIV_BITS - BRIGHT_BITS);

    localparam logic [6:0] HEX_MAP [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] number = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;
    logic [1:0]  brightness = 2'd3;
    logic        busy;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    logic [3:0]  dec_nibble = '0;
    logic [6:0]  dec_seg;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since reset plus the two buffers as plain values.
    int          m_t;
    logic [15:0] m_pend_num, m_disp_num;
    logic [3:0]  m_pend_blank, m_disp_blank, m_pend_dp, m_disp_dp;
    logic        m_busy;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS      (DIGITS),
        .DIV_BITS    (DIV_BITS),
        .BRIGHT_BITS (BRIGHT_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .blank      (blank),
        .dp         (dp),
        .load       (load),
        .brightness (brightness),
        .busy       (busy),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .digit_idx  (digit_idx)
    );

    seg_hex_decode u_dec (
        .nibble (dec_nibble),
        .seg    (dec_seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected pins while digit d is in its slot at prescaler count c.
    task automatic predict(input int d, input int c);
        logic [15:0] upper;
        logic [3:0]  nib;
        bit          dark;
        upper = m_disp_num >> (4 * d);
        nib   = upper[3:0];
        dark  = ((c / PWM_STEP) > int'(brightness)) || m_disp_blank[d];
`ifdef SEG_SCAN_LZS_EN
        if (d > 0 && upper == 16'h0) dark = 1'b1;
`endif
        if (dark) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dpn = 1'b1;
        end else begin
            e_an  = 4'hF ^ (4'd1 << d);
            e_seg = HEX_MAP[nib];
            e_dpn = ~m_disp_dp[d];
        end
    endtask

    task automatic step(input bit r, input bit ld);
        int d;
        int c;
        bit frame_end;
        rst  = r;
        load = ld;
        @(posedge clk);
        if (r) begin
            m_t          = 0;
            m_pend_num   = '0;
            m_disp_num   = '0;
            m_pend_blank = '1;
            m_disp_blank = '1;
            m_pend_dp    = '0;
            m_disp_dp    = '0;
            m_busy       = 1'b0;
            e_an         = 4'hF;
            e_seg        = 7'h7F;
            e_dpn        = 1'b1;
        end else begin
            d = (m_t / SLOT) % DIGITS;
            c = m_t % SLOT;
            frame_end = (m_t % FRAME) == FRAME - 1;
            predict(d, c);
            if (frame_end) begin
                m_disp_num   = m_pend_num;
                m_disp_blank = m_pend_blank;
                m_disp_dp    = m_pend_dp;
            end
            if (ld) begin
                m_pend_num   = number;
                m_pend_blank = blank;
                m_pend_dp    = dp;
                m_busy       = 1'b1;
            end else if (frame_end) begin
                m_busy = 1'b0;
            end
            m_t++;
        end
        @(negedge clk);
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp_n", dp_n, e_dpn);
        check("busy", busy, m_busy);
        check("digit_idx", digit_idx, (m_t / SLOT) % DIGITS);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic run_to_digit(input int d);
        for (int i = 0; i < FRAME && ((m_t / SLOT) % DIGITS) != d; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] num, input logic [3:0] blk, input logic [3:0] pt);
        number = num;
        blank  = blk;
        dp     = pt;
        step(1'b0, 1'b1);
    endtask

    initial begin
        // Decoder alone, all 16 nibbles.
        for (int i = 0; i < 16; i++) begin
            dec_nibble = 4'(i);
            #1;
            check("hex_decode", dec_seg, HEX_MAP[i]);
        end

        @(negedge clk);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(FRAME);                               // dark frame, no load

        brightness = 2'd3;
        do_load(16'h1234, 4'b0000, 4'b0100);
        run(FRAME + 20);

        run_to_digit(1);
        do_load(16'h5678, 4'b0000, 4'b0000);
        run(5);
        do_load(16'h9ABC, 4'b0000, 4'b1001);      // last write wins
        run(2 * FRAME);

        brightness = 2'd0;
        run(FRAME);
        brightness = 2'd2;
        run(FRAME);
        brightness = 2'd3;

        run_to_digit(2);
        run(5);
        number = 16'hFFFF;
        blank  = 4'b0000;
        dp     = 4'b1111;
        step(1'b1, 1'b1);                         // reset beats load
        run(FRAME);

        do_load(16'h0070, 4'b0000, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0000, 4'b1111);
        run(2 * FRAME);

        // Commit-cycle collision: load exactly on the frame boundary.
        run_to_digit(3);
        run(SLOT - 1);
        do_load(16'hBEEF, 4'b0010, 4'b0001);
        run(2 * FRAME);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                number = 16'($urandom);
                step(1'b1, 1'($urandom));
            end else if ($urandom_range(0, 23) == 0) begin
                number = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                dp     = 4'($urandom);
                step(1'b0, 1'b1);
            end else begin
                step(1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised time-multiplexed seven-segment display driver. It is the successor to the fixed 4-digit display driver used at top level.
- Adds: any digit count, per-digit blank and decimal point, PWM brightness, and tear-free double-buffered loading via a load/busy handshake.
- Sits in the top-level clock domain and drives the board's active-low seg/an pins directly.

Parameters:
DIGITS, 4, number of digits/anodes (1..8)
DIV_BITS, 16, prescaler width; one digit slot = 2^DIV_BITS clk cycles
BRIGHT_BITS, 3, brightness resolution; must be < DIV_BITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
number  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i (digit 0 = rightmost)
blank  in  DIGITS  per-digit blank mask, 1 = digit dark
dp  in  DIGITS  per-digit decimal point, 1 = lit
load  in  1  one-cycle strobe; captures number/blank/dp into the pending buffer
brightness  in  BRIGHT_BITS  duty level; sampled every cycle, not buffered
busy  out  1  pending buffer not yet committed to the display buffer
seg  out  7  active-low segments, seg[0]=a .. seg[6]=g
dp_n  out  1  active-low decimal point
an  out  DIGITS  active-low anodes, an[i] = digit i
digit_idx  out  max(1,$clog2(DIGITS))  digit currently in its slot

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - div_cnt=0, digit_idx=0, busy=0.
  - Pending and display buffers: number=0, blank=all ones, dp=0.
  - Outputs: an=all ones, seg=7'h7F, dp_n=1.
  - Reset asserted mid-frame or with load high wins: load is ignored that cycle.
- Prescaler:
  - div_cnt increments every cycle and wraps at all ones.
  - slot_tick = (div_cnt == all ones).
  - On slot_tick, digit_idx advances; DIGITS-1 wraps to 0.
- Load handshake:
  - load=1 copies the inputs into the pending buffer and sets busy=1 the next cycle.
  - load while busy=1 overwrites the pending buffer (last write wins); busy stays 1.
- Commit:
  - Happens on the slot_tick where digit_idx wraps DIGITS-1 -> 0. The pending buffer is copied into the display buffer and busy clears the next cycle.
  - load on the same cycle as commit: the new inputs go to the pending buffer and busy stays 1. The display buffer takes the old pending contents.
- Frames never mix old and new values.
- Brightness:
  - Let top = div_cnt[DIV_BITS-1 -: BRIGHT_BITS].
  - Anode enabled when top <= brightness.
  - brightness=all ones gives full on; 0 gives 1/2^BRIGHT_BITS duty.
- Outputs are registered and computed from the current digit_idx, div_cnt and display buffer, giving 1-cycle latency. an, seg and dp_n change in the same cycle.
- Enabled digit:
  - an = ~(1<<digit_idx).
  - seg = hex decode of the nibble; dp_n = ~dp bit.
- Dark digit (disabled slot or blanked digit): an=all ones, seg=7'h7F, dp_n=1.
- Hex map (active-low, bits g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- DIGITS=1: digit_idx is fixed at 0, and every slot_tick is a commit point.

Optional Feature:
Macro SEG_SCAN_LZS_EN.
- Defined: leading-zero suppression. Every digit above the most significant non-zero nibble of the display buffer is forced dark. Digit 0 is never suppressed, so 0 shows as "0". Suppression ORs with blank; dp is still suppressed with the digit.
- Undefined: no suppression logic is present and only blank controls darkness.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 7'h7F constant.
  - hex_to_seg function (4-bit -> 7-bit active-low).
  - Digit-index width helper.
- One sub-module, seg_hex_decode (combinational wrapper around hex_to_seg), so the decode can be unit-tested alone.
- Scan, handshake and PWM stay in seg_scan_display.

Test Plan:
All runs use DIGITS=4, DIV_BITS=4, BRIGHT_BITS=2.
1. Reset -> an=4'hF, seg=7'h7F, dp_n=1, busy=0, digit_idx=0; the display stays dark for a full frame with no load.
2. load number=16'h1234, blank=0, dp=4'b0100, brightness=3 -> busy=1 until the first wrap to digit 0.
   - Then an cycles 1110, 1101, 1011, 0111, 16 cycles each.
   - seg cycles 19, 30, 24, 79.
   - dp_n=0 only while an=1011.
3. Mid-frame load 16'h5678 while digit_idx=1, then load 16'h9ABC while busy=1 -> the rest of the frame still shows 1234. After the commit the display shows 9ABC; 5678 is never displayed.
4. brightness=0 -> in each slot the anode is low only for div_cnt 0..3 (4 of 16 cycles); brightness=2 -> low for div_cnt 0..11.
5. rst asserted at digit_idx=2 with load=1 -> next cycle all reset values hold, busy=0, and the display buffer is blanked.
6. With SEG_SCAN_LZS_EN defined, load 16'h0070 -> digits 3 and 2 dark, digit 1 shows 78, digit 0 shows 40. Load 16'h0000 -> only digit 0 is lit, showing 40.
